fetch_stage: RTL and testbench



---
 rtl/riscv_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 53 +++++
 rtl/fetch_stage.sv | 127 ++++++++++++
 tb/tb_fetch_stage.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared RV32I core types and constants (word width, NOP encoding,
//            fetch queue entry layout).
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int XLEN = 32;

    // ADDI x0, x0, 0 - what decode sees while nothing has been fetched
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Synchronous FIFO of fetch entries with flush, push, pop and an
//            occupancy count. The head entry is read combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  fetch_entry_t             i_push_data,
    input  logic                     i_pop,
    output fetch_entry_t             o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = $clog2(DEPTH) + 1;

    fetch_entry_t      r_mem [DEPTH];
    logic [c_aw-1:0]   r_wptr;
    logic [c_aw-1:0]   r_rptr;
    logic [c_cw-1:0]   r_count;

    // Pointer and occupancy bookkeeping; flush discards everything queued.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + c_aw'(1);
            if (i_pop)  r_rptr <= r_rptr + c_aw'(1);
            r_count <= r_count + c_cw'(i_push) - c_cw'(i_pop);
        end
    end

    // Entry storage; data needs no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wptr] <= i_push_data;
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : RV32I instruction fetch. Owns the PC, issues in-order requests
//            over req/gnt/rvalid, buffers returned words for decode and
//            discards responses made stale by execute redirects.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

    localparam int              c_aw    = $clog2(DEPTH);
    localparam int              c_cw    = $clog2(DEPTH) + 1;
    localparam logic [c_cw:0]   c_depth = (c_cw + 1)'(DEPTH);

    logic [XLEN-1:0]  r_pc;
    logic [c_cw-1:0]  r_outstanding;
    logic [c_cw-1:0]  r_drop_cnt;
    logic [XLEN-1:0]  r_pcq [DEPTH];
    logic [c_aw-1:0]  r_pcq_wptr;
    logic [c_aw-1:0]  r_pcq_rptr;

    logic [c_cw-1:0]  w_count;
    logic [c_cw:0]    w_credit;
    logic             w_grant;
    logic             w_rsp;
    logic             w_stale;
    logic             w_push;
    logic             w_pop;
    fetch_entry_t     w_push_data;
    fetch_entry_t     w_head;
    logic             w_unused;

    // Credit counts every slot a request could still land in, so the FIFO
    // can never overflow; only registered state feeds it.
    assign w_credit  = {1'b0, r_outstanding} + {1'b0, w_count};
    assign imem_req  = !rst && !redirect_valid && (w_credit < c_depth);
    assign imem_addr = r_pc;
    assign w_grant   = imem_req && imem_gnt;

    // A response with nothing outstanding (e.g. just after reset) is ignored.
    assign w_rsp     = imem_rvalid && (r_outstanding != '0);
    assign w_stale   = w_rsp && (r_drop_cnt != '0);
    assign w_push    = w_rsp && !w_stale && !redirect_valid;
    assign w_pop     = id_valid && id_ready && !redirect_valid;

    assign w_push_data = '{instr: imem_rdata, pc: r_pcq[r_pcq_rptr]};

    // The low bits of a redirect target are forced to word alignment.
    assign w_unused = ^redirect_pc[1:0];

    // PC, in-flight accounting and PC-queue pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_pcq_wptr    <= '0;
            r_pcq_rptr    <= '0;
        end else begin
            r_outstanding <= r_outstanding + c_cw'(w_grant) - c_cw'(w_rsp);
            if (redirect_valid) begin
                r_pc       <= {redirect_pc[31:2], 2'b00};
                // Everything still in flight after this cycle is stale,
                // including responses already marked for dropping by an
                // earlier redirect, so the new drop count is simply what
                // remains outstanding.
                r_drop_cnt <= r_outstanding - c_cw'(w_rsp);
                r_pcq_wptr <= '0;
                r_pcq_rptr <= '0;
            end else begin
                if (w_grant) begin
                    r_pc       <= r_pc + 32'd4;
                    r_pcq_wptr <= r_pcq_wptr + c_aw'(1);
                end
                if (w_stale) r_drop_cnt <= r_drop_cnt - c_cw'(1);
                if (w_push)  r_pcq_rptr <= r_pcq_rptr + c_aw'(1);
            end
        end
    end

    // Remember the PC of each granted request until its data returns.
    always_ff @(posedge clk) begin
        if (w_grant) r_pcq[r_pcq_wptr] <= r_pc;
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (redirect_valid),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    assign id_valid = (w_count != '0);
    assign id_instr = id_valid ? w_head.instr : NOP_INSTR;
    assign id_pc    = id_valid ? w_head.pc    : '0;

    // A response with nothing outstanding means the memory broke the handshake.
    a_rvalid_has_owner: assert property (@(posedge clk) disable iff (rst)
        imem_rvalid |-> (r_outstanding != '0));

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Self-checking bench for fetch_stage: queue-based reference model,
//            directed scenarios with literal expectations, random soak.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc)
    );

    // Reference model: in-flight requests (with memory due time and a
    // "still wanted" flag) and the queue of instructions awaiting decode.
    typedef struct packed {
        logic [31:0] addr;
        int          due;
        bit          live;
    } infl_t;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    infl_t       m_inf[$];
    ent_t        m_fifo[$];
    logic [31:0] m_pc = RESET_PC;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Stimulus knobs
    bit          s_rst = 1'b1;
    bit          s_redir = 1'b0;
    bit          s_ready = 1'b1;
    logic [31:0] s_redir_pc = '0;
    int          gnt_pct = 100;
    int          lat_min = 1;
    int          lat_max = 1;
    logic [31:0] salt = '0;

    // What the DUT showed in the most recent cycle
    bit          o_valid, o_req, o_pop, o_grant;
    logic [31:0] o_pc, o_addr, o_instr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        bit          exp_req, exp_valid;
        logic [31:0] exp_instr, exp_pc;
        infl_t       e;
        @(negedge clk);
        rst            = s_rst;
        redirect_valid = s_redir;
        redirect_pc    = s_redir_pc;
        id_ready       = s_ready;
        imem_gnt       = ($urandom_range(0, 99) < gnt_pct);
        if (m_inf.size() > 0 && m_inf[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = m_inf[0].addr ^ salt;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        exp_req   = !s_rst && !s_redir && (m_inf.size() + m_fifo.size() < DEPTH);
        exp_valid = (m_fifo.size() != 0);
        exp_instr = exp_valid ? m_fifo[0].instr : 32'h0000_0013;
        exp_pc    = exp_valid ? m_fifo[0].pc    : 32'h0;
        chk("imem_req",  {31'b0, imem_req}, {31'b0, exp_req});
        chk("imem_addr", imem_addr, m_pc);
        chk("id_valid",  {31'b0, id_valid}, {31'b0, exp_valid});
        chk("id_instr",  id_instr, exp_instr);
        chk("id_pc",     id_pc, exp_pc);
        o_valid = id_valid;
        o_req   = imem_req;
        o_pc    = id_pc;
        o_addr  = imem_addr;
        o_instr = id_instr;
        o_pop   = id_valid && s_ready && !s_redir && !s_rst;
        o_grant = imem_req && imem_gnt;
        // Advance the model by one clock
        if (s_rst) begin
            m_pc = RESET_PC;
            m_inf.delete();
            m_fifo.delete();
        end else begin
            e = '0;
            if (imem_rvalid) e = m_inf.pop_front();
            if (s_redir) begin
                m_pc = {s_redir_pc[31:2], 2'b00};
                m_fifo.delete();
                foreach (m_inf[i]) m_inf[i].live = 1'b0;
            end else begin
                if (exp_valid && s_ready) void'(m_fifo.pop_front());
                if (imem_rvalid && e.live) m_fifo.push_back('{instr: imem_rdata, pc: e.addr});
                if (exp_req && imem_gnt) begin
                    m_inf.push_back('{addr: m_pc, due: cyc + $urandom_range(lat_min, lat_max), live: 1'b1});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        cyc++;
    endtask

    function automatic bit rsp_due_now();
        return (m_inf.size() > 0) && (m_inf[0].due <= cyc);
    endfunction

    initial begin
        int          first_valid;
        int          grants;
        int          bad;
        int          pops;
        bit          found;
        logic [31:0] got [4];

        // ---- Reset and zero-wait streaming ----
        s_rst = 1; gnt_pct = 100; lat_min = 1; lat_max = 1; salt = '0; s_ready = 1;
        repeat (3) step();
        chk("rst_addr",  o_addr, 32'h0);
        chk("rst_valid", {31'b0, o_valid}, 32'h0);
        chk("rst_instr", o_instr, 32'h0000_0013);
        s_rst = 0;
        first_valid = -1;
        for (int k = 0; k < 6; k++) begin
            step();
            if (k == 0) chk("first_req", {31'b0, o_req}, 32'h1);
            if (o_valid && first_valid < 0) first_valid = k;
            if (k >= 2 && k <= 4) got[k-2] = o_pc;
        end
        chk("first_valid_cycle", first_valid, 2);
        chk("stream_pc0", got[0], 32'h0);
        chk("stream_pc1", got[1], 32'h4);
        chk("stream_pc2", got[2], 32'h8);

        // ---- Decode stall from a fresh start ----
        s_rst = 1; step(); s_rst = 0;
        s_ready = 0; grants = 0; bad = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (o_grant) grants++;
            if (k >= 2 && (!o_valid || o_pc != 32'h0)) bad++;
        end
        chk("stall_grants", grants, 4);
        chk("stall_head_stable", bad, 0);
        s_ready = 1; pops = 0;
        for (int k = 0; k < 20 && pops < 4; k++) begin
            step();
            if (o_pop) begin got[pops] = o_pc; pops++; end
        end
        chk("release_pops", pops, 4);
        chk("release_pc0", got[0], 32'h0);
        chk("release_pc1", got[1], 32'h4);
        chk("release_pc2", got[2], 32'h8);
        chk("release_pc3", got[3], 32'hC);

        // ---- Redirect with two fetches in flight, 2-cycle memory ----
        salt = 32'h5A5A_0000; lat_min = 2; lat_max = 2;
        for (int k = 0; k < 20 && m_inf.size() != 2; k++) step();
        chk("two_in_flight", m_inf.size(), 2);
        s_redir = 1; s_redir_pc = 32'h100; step(); s_redir = 0;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (o_pop) begin found = 1; chk("redir_first_pc", o_pc, 32'h100); end
        end
        chk("redir_found", {31'b0, found}, 32'h1);

        // ---- Redirect together with rvalid, then a second redirect ----
        for (int k = 0; k < 20 && !rsp_due_now(); k++) step();
        chk("rvalid_aligned", {31'b0, rsp_due_now()}, 32'h1);
        s_redir = 1; s_redir_pc = 32'h180; step();
        chk("redir_rvalid_seen", {31'b0, imem_rvalid}, 32'h1);
        s_redir_pc = 32'h200; step(); s_redir = 0;
        found = 0; bad = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (o_pop) begin
                if (!found) chk("redir2_first_pc", o_pc, 32'h200);
                found = 1;
                if (o_pc < 32'h200) bad++;
            end
        end
        chk("redir2_found", {31'b0, found}, 32'h1);
        chk("redir2_no_stale", bad, 0);

        // ---- Misaligned redirect target ----
        s_redir = 1; s_redir_pc = 32'h103; step(); s_redir = 0;
        step();
        chk("misaligned_addr", o_addr, 32'h100);

        // ---- Reset mid-operation with a loaded FIFO and two outstanding ----
        s_ready = 0; lat_min = 3; lat_max = 3;
        for (int k = 0; k < 30 && !(m_fifo.size() >= 2 && m_inf.size() == 2); k++) step();
        chk("loaded_before_rst", {31'b0, (m_fifo.size() >= 2 && m_inf.size() == 2)}, 32'h1);
        s_rst = 1; step(); s_rst = 0;
        step();
        chk("post_rst_valid", {31'b0, o_valid}, 32'h0);
        chk("post_rst_addr",  o_addr, RESET_PC);
        chk("post_rst_req",   {31'b0, o_req}, 32'h1);

        // ---- Random soak ----
        gnt_pct = 60; lat_min = 1; lat_max = 4;
        for (int k = 0; k < 3000; k++) begin
            s_rst      = ($urandom_range(0, 199) == 0);
            s_redir    = ($urandom_range(0, 29) == 0);
            s_redir_pc = $urandom;
            s_ready    = ($urandom_range(0, 99) < 70);
            salt       = $urandom;
            step();
        end
        s_rst = 0; s_redir = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
